// File: rtl/trap_csr_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trap_csr_unit_pkg
// Purpose  : Shared CSR addresses, csr_op encodings and trap FSM states
// Revision : 1.0 - initial release
// ============================================================================
package trap_csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    localparam logic [1:0] CSR_OP_NONE  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MSTATUS_MPP_M  = 32'h0000_1800;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old_val,
                                              input logic [31:0] wdata);
        case (op)
            CSR_OP_WRITE: return wdata;
            CSR_OP_SET:   return old_val | wdata;
            CSR_OP_CLEAR: return old_val & ~wdata;
            default:      return old_val;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_csr_unit_csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : csr_counter64
// Purpose  : 64-bit counter with increment enable and lo/hi write ports;
//            only built when CSR_COUNTERS_EN is defined
// Revision : 1.0 - initial release
// ============================================================================
`ifdef CSR_COUNTERS_EN
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] r_count;

    // A write to either half suppresses that cycle's increment of the whole counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 64'd0;
        end else if (wr_lo) begin
            r_count <= {r_count[63:32], wdata};
        end else if (wr_hi) begin
            r_count <= {wdata, r_count[31:0]};
        end else if (inc_en) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign count = r_count;

endmodule
`endif
`default_nettype wire

// File: rtl/trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : trap_csr_unit
// Purpose  : M-mode CSR file and ECALL/MRET trap sequencer with PC redirect;
//            CSR_COUNTERS_EN adds 64-bit mcycle/minstret counters
// Revision : 1.0 - initial release
// ============================================================================
module trap_csr_unit
    import trap_csr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_ecall,
    input  logic        ex_is_mret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        instr_retire,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush
);

    state_e      r_state;
    logic        r_mie;
    logic        r_mpie;
    logic [29:0] r_mtvec;
    logic [29:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mscratch;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;

    logic        w_idle_valid;
    logic        w_ecall;
    logic        w_mret;
    logic        w_csr_we;
    logic [31:0] w_new;

    // Lower-priority requests in the same cycle are dropped entirely
    assign w_idle_valid = ex_valid && (r_state == ST_IDLE);
    assign w_ecall      = w_idle_valid && ex_is_ecall;
    assign w_mret       = w_idle_valid && ex_is_mret && !ex_is_ecall;
    assign w_csr_we     = w_idle_valid && !ex_is_ecall && !ex_is_mret
                          && (csr_op != CSR_OP_NONE);
    assign w_new        = csr_apply(csr_op, csr_rdata, csr_wdata);

`ifdef CSR_COUNTERS_EN
    logic [63:0] w_mcycle;
    logic [63:0] w_minstret;
    logic        w_unused;

    assign w_unused = ^ex_pc[1:0];

    csr_counter64 u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .wr_lo  (w_csr_we && (csr_addr == CSR_MCYCLE)),
        .wr_hi  (w_csr_we && (csr_addr == CSR_MCYCLEH)),
        .wdata  (w_new),
        .count  (w_mcycle)
    );

    csr_counter64 u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (instr_retire),
        .wr_lo  (w_csr_we && (csr_addr == CSR_MINSTRET)),
        .wr_hi  (w_csr_we && (csr_addr == CSR_MINSTRETH)),
        .wdata  (w_new),
        .count  (w_minstret)
    );
`else
    logic w_unused;

    assign w_unused = ^{instr_retire, ex_pc[1:0]};
`endif

    always_comb begin
        csr_rdata = 32'd0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata    = MSTATUS_MPP_M;
                csr_rdata[3] = r_mie;
                csr_rdata[7] = r_mpie;
            end
            CSR_MTVEC:     csr_rdata = {r_mtvec, 2'b00};
            CSR_MEPC:      csr_rdata = {r_mepc, 2'b00};
            CSR_MCAUSE:    csr_rdata = r_mcause;
            CSR_MSCRATCH:  csr_rdata = r_mscratch;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE:    csr_rdata = w_mcycle[31:0];
            CSR_MCYCLEH:   csr_rdata = w_mcycle[63:32];
            CSR_MINSTRET:  csr_rdata = w_minstret[31:0];
            CSR_MINSTRETH: csr_rdata = w_minstret[63:32];
`endif
            default:       csr_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'd0;
            r_mie         <= 1'b0;
            r_mpie        <= 1'b0;
            r_mtvec       <= RESET_MTVEC[31:2];
            r_mepc        <= 30'd0;
            r_mcause      <= 32'd0;
            r_mscratch    <= 32'd0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ecall) begin
                        r_mepc        <= ex_pc[31:2];
                        r_mcause      <= MCAUSE_ECALL_M;
                        r_mpie        <= r_mie;
                        r_mie         <= 1'b0;
                        r_redirect_pc <= {r_mtvec, 2'b00};
                        r_redirect    <= 1'b1;
                        r_state       <= ST_REDIRECT;
                    end else if (w_mret) begin
                        r_mie         <= r_mpie;
                        r_mpie        <= 1'b1;
                        r_redirect_pc <= {r_mepc, 2'b00};
                        r_redirect    <= 1'b1;
                        r_state       <= ST_REDIRECT;
                    end else if (w_csr_we) begin
                        case (csr_addr)
                            CSR_MSTATUS: begin
                                r_mie  <= w_new[3];
                                r_mpie <= w_new[7];
                            end
                            CSR_MTVEC:    r_mtvec    <= w_new[31:2];
                            CSR_MEPC:     r_mepc     <= w_new[31:2];
                            CSR_MCAUSE:   r_mcause   <= w_new;
                            CSR_MSCRATCH: r_mscratch <= w_new;
                            default: ;
                        endcase
                    end
                end
                ST_REDIRECT: r_state <= ST_IDLE;
                default:     r_state <= ST_IDLE;
            endcase
        end
    end

    assign redirect_valid = r_redirect;
    assign flush          = r_redirect;
    assign redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_trap_csr_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_csr_unit
// Purpose  : Directed and randomized self-checking bench for trap_csr_unit;
//            honours CSR_COUNTERS_EN when defined
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_csr_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_is_ecall;
    logic        ex_is_mret;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        instr_retire;
    logic [31:0] csr_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 1'b0;

    trap_csr_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_is_ecall    (ex_is_ecall),
        .ex_is_mret     (ex_is_mret),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .instr_retire   (instr_retire),
        .csr_rdata      (csr_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush)
    );

    always #5 clk = ~clk;

    // Reference state: architectural CSR values plus a pending-redirect flag
    bit          m_redirect;
    logic [31:0] m_rpc;
    bit          m_mie;
    bit          m_mpie;
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mscratch;
    logic [63:0] m_mcycle;
    logic [63:0] m_minstret;
    logic [63:0] m_nc;
    logic [63:0] m_ni;
    logic [31:0] m_old;
    logic [31:0] m_new;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h0000_1800 | (32'(m_mie) << 3) | (32'(m_mpie) << 7);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h340: return m_mscratch;
`ifdef CSR_COUNTERS_EN
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Reference model advances on every rising edge from the inputs held there
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_redirect = 1'b0; m_rpc = 32'd0; m_mie = 1'b0; m_mpie = 1'b0;
                m_mtvec = 32'h100; m_mepc = 32'd0; m_mcause = 32'd0;
                m_mscratch = 32'd0; m_mcycle = 64'd0; m_minstret = 64'd0;
            end else begin
                m_nc = m_mcycle + 64'd1;
                m_ni = m_minstret + (instr_retire ? 64'd1 : 64'd0);
                if (m_redirect) begin
                    m_redirect = 1'b0;
                end else if (ex_valid && ex_is_ecall) begin
                    m_mepc = {ex_pc[31:2], 2'b00};
                    m_mcause = 32'd11;
                    m_mpie = m_mie;
                    m_mie = 1'b0;
                    m_rpc = m_mtvec;
                    m_redirect = 1'b1;
                end else if (ex_valid && ex_is_mret) begin
                    m_mie = m_mpie;
                    m_mpie = 1'b1;
                    m_rpc = m_mepc;
                    m_redirect = 1'b1;
                end else if (ex_valid && csr_op != 2'b00) begin
                    m_old = model_read(csr_addr);
                    if (csr_op == 2'b01)      m_new = csr_wdata;
                    else if (csr_op == 2'b10) m_new = m_old | csr_wdata;
                    else                      m_new = m_old & ~csr_wdata;
                    case (csr_addr)
                        12'h300: begin m_mie = m_new[3]; m_mpie = m_new[7]; end
                        12'h305: m_mtvec = m_new & 32'hFFFF_FFFC;
                        12'h341: m_mepc = m_new & 32'hFFFF_FFFC;
                        12'h342: m_mcause = m_new;
                        12'h340: m_mscratch = m_new;
`ifdef CSR_COUNTERS_EN
                        12'hB00: m_nc = {m_mcycle[63:32], m_new};
                        12'hB80: m_nc = {m_new, m_mcycle[31:0]};
                        12'hB02: m_ni = {m_minstret[63:32], m_new};
                        12'hB82: m_ni = {m_new, m_minstret[31:0]};
`endif
                        default: ;
                    endcase
                end
                m_mcycle = m_nc;
                m_minstret = m_ni;
            end
        end
    end

    // Compare process: outputs checked mid-cycle against the reference
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("cmp_rdata", csr_rdata, model_read(csr_addr));
                check("cmp_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redirect});
                check("cmp_flush", {31'd0, flush}, {31'd0, m_redirect});
                if (m_redirect) check("cmp_redirect_pc", redirect_pc, m_rpc);
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic ec, input logic mr,
                         input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        ex_valid = v; ex_pc = pc; ex_is_ecall = ec; ex_is_mret = mr;
        csr_op = op; csr_addr = a; csr_wdata = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] addrs [12] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340, 12'hB00,
                                12'hB80, 12'hB02, 12'hB82, 12'h000, 12'h7C0, 12'h301};

    initial begin
        rst = 1'b1;
        instr_retire = 1'b0;
        drive(0, 32'd0, 0, 0, 2'b00, 12'h000, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;

        drive(0, 32'd0, 0, 0, 2'b00, 12'h305, 32'd0); #1;
        check("reset_mtvec", csr_rdata, 32'h0000_0100);
        drive(0, 32'd0, 0, 0, 2'b00, 12'h300, 32'd0); #1;
        check("reset_mstatus", csr_rdata, 32'h0000_1800);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        check("reset_flush", {31'd0, flush}, 32'd0);

        // set MIE, then ECALL
        drive(1, 32'd0, 0, 0, 2'b10, 12'h300, 32'h8); step();
        drive(1, 32'h40, 1, 0, 2'b00, 12'h000, 32'd0); step();
        check("ecall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("ecall_flush", {31'd0, flush}, 32'd1);
        check("ecall_redirect_pc", redirect_pc, 32'h0000_0100);
        drive(0, 32'd0, 0, 0, 2'b00, 12'h341, 32'd0); step();
        check("ecall_mepc", csr_rdata, 32'h0000_0040);
        drive(0, 32'd0, 0, 0, 2'b00, 12'h342, 32'd0); #1;
        check("ecall_mcause", csr_rdata, 32'd11);
        drive(0, 32'd0, 0, 0, 2'b00, 12'h300, 32'd0); #1;
        check("ecall_mstatus", csr_rdata, 32'h0000_1880);

        // write mepc, MRET the next cycle
        drive(1, 32'd0, 0, 0, 2'b01, 12'h341, 32'h44); step();
        drive(1, 32'h10, 0, 1, 2'b00, 12'h000, 32'd0); step();
        check("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        check("mret_redirect_pc", redirect_pc, 32'h0000_0044);
        drive(0, 32'd0, 0, 0, 2'b00, 12'h300, 32'd0); step();
        check("mret_mstatus", csr_rdata, 32'h0000_1888);
        check("mret_one_cycle", {31'd0, redirect_valid}, 32'd0);

        // ECALL wins over a same-cycle CSR write
        drive(1, 32'h80, 1, 0, 2'b01, 12'h340, 32'hDEAD_BEEF); step();
        drive(0, 32'd0, 0, 0, 2'b00, 12'h340, 32'd0); step();
        check("ecall_drops_csr_write", csr_rdata, 32'd0);

        // second ECALL lands in REDIRECT and is ignored
        drive(1, 32'h200, 1, 0, 2'b00, 12'h000, 32'd0); step();
        drive(1, 32'h300, 1, 0, 2'b00, 12'h000, 32'd0); #1;
        check("b2b_first_redirect", {31'd0, redirect_valid}, 32'd1);
        step();
        drive(0, 32'd0, 0, 0, 2'b00, 12'h341, 32'd0); #1;
        check("b2b_single_redirect", {31'd0, redirect_valid}, 32'd0);
        check("b2b_mepc_first", csr_rdata, 32'h0000_0200);

`ifdef CSR_COUNTERS_EN
        drive(1, 32'd0, 0, 0, 2'b01, 12'hB00, 32'hFFFF_FFFE); step();
        drive(1, 32'd0, 0, 0, 2'b01, 12'hB80, 32'hFFFF_FFFF); step();
        drive(0, 32'd0, 0, 0, 2'b00, 12'hB80, 32'd0);
        step(); step(); step();
        check("mcycle_wrap_hi", csr_rdata, 32'd0);
        drive(0, 32'd0, 0, 0, 2'b00, 12'hB00, 32'd0); #1;
        check("mcycle_wrap_lo", csr_rdata, 32'd1);
`else
        drive(0, 32'd0, 0, 0, 2'b00, 12'hB00, 32'd0); #1;
        check("no_counter_read", csr_rdata, 32'd0);
`endif

        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(399, 0) == 0);
            ex_valid     = ($urandom_range(3, 0) != 0);
            ex_pc        = $urandom;
            ex_is_ecall  = ($urandom_range(7, 0) == 0);
            ex_is_mret   = ($urandom_range(7, 0) == 0);
            csr_op       = 2'($urandom);
            csr_addr     = addrs[$urandom_range(11, 0)];
            csr_wdata    = ($urandom_range(3, 0) == 0) ? 32'h0000_0088 : $urandom;
            instr_retire = 1'($urandom);
            step();
        end
        rst = 1'b0;
        ex_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
